// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline types and widths for the hazard/stall unit.
// Contents: stall FSM state encoding, register-index width, zero register,
// stall counter width and its saturation value.
package hazard_stall_unit_pkg;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL1 = 2'd1,
        ST_FLUSH  = 2'd2
    } stall_state_e;
endpackage

// File: rtl/hazard_stall_unit_compare.sv
// hazard_compare: combinational RAW match of one later-stage destination against ID sources.
// Ports: dest_i (destination reg), wb_en_i (stage writes back), src1_i/src2_i (ID sources),
//        two_src_i (src2 is read), match_o (hazard against this stage; r0 never matches).
module hazard_compare
    import hazard_stall_unit_pkg::*;
(
    input  logic [REG_W-1:0] dest_i,
    input  logic             wb_en_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             two_src_i,
    output logic             match_o
);
    assign match_o = wb_en_i & (dest_i != REG_ZERO) & ((dest_i == src1_i) | (two_src_i & (dest_i == src2_i)));
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: detects data hazards in ID and sequences freeze/bubble/flush control.
// Ports: clk, rst (sync, active-high); id_valid_i, src1_i, src2_i, two_src_i (ID instruction);
//        exe_dest_i, exe_wb_en_i, exe_mem_r_en_i (EXE stage); mem_dest_i, mem_wb_en_i (MEM stage);
//        forward_en_i, can_forward_i, branch_taken_i (pipeline control);
//        freeze_o (hold PC, IF/ID), bubble_o (NOP into ID/EX), flush_o (clear IF/ID),
//        stall_count_o (saturating count of freeze cycles).
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             two_src_i,
    input  logic [REG_W-1:0] exe_dest_i,
    input  logic             exe_wb_en_i,
    input  logic             exe_mem_r_en_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_wb_en_i,
    input  logic             forward_en_i,
    input  logic             can_forward_i,
    input  logic             branch_taken_i,
    output logic             freeze_o,
    output logic             bubble_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] stall_count_o
);
    stall_state_e     state_q, state_d;
    logic             rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             exe_match, mem_match, hz_exe, hz_mem, cost1, cost2;

    hazard_compare u_exe_cmp (
        .dest_i    (exe_dest_i),
        .wb_en_i   (exe_wb_en_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .two_src_i (two_src_i),
        .match_o   (exe_match)
    );

    hazard_compare u_mem_cmp (
        .dest_i    (mem_dest_i),
        .wb_en_i   (mem_wb_en_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .two_src_i (two_src_i),
        .match_o   (mem_match)
    );

    always_comb begin
        hz_exe = id_valid_i & exe_match;
        hz_mem = id_valid_i & mem_match;
        // Without forwarding an EXE producer needs two bubbles; with forwarding only a
        // load in EXE, or a MEM match the forwarder cannot serve, costs one.
        cost2 = ~forward_en_i & hz_exe;
        cost1 = forward_en_i ? ((hz_exe & exe_mem_r_en_i) | (hz_mem & ~can_forward_i)) : hz_mem;
        flush_o = ~rst & branch_taken_i;
        freeze_o = ~rst & ~branch_taken_i & (((state_q == ST_STALL1) & rem_q) | ((state_q == ST_RUN) & (cost1 | cost2)));
        bubble_o = flush_o | freeze_o | (~rst & (state_q == ST_FLUSH));
        state_d = branch_taken_i ? ST_FLUSH : ((state_q == ST_RUN) & cost2) ? ST_STALL1 : ST_RUN;
        rem_d = (state_d == ST_STALL1);
        cnt_d = (freeze_o & (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            rem_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count_o = cnt_q;
endmodule
